// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR pseudo-random stream generator.
package lfsr_pkg;

  localparam int unsigned STEP_BITS = 64;
  localparam int unsigned CNT_BITS  = 8;
  localparam int unsigned COUNT_BITS = 32;

  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [31:0] TAPS32 = 32'h80200003;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Fibonacci step on a zero-extended register; callers truncate to their width.
  function automatic logic [STEP_BITS-1:0] lfsr_step(input logic [STEP_BITS-1:0] r,
                                                     input logic [STEP_BITS-1:0] taps);
    return {r[STEP_BITS-2:0], ^(r & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// One parametrised Fibonacci LFSR register with step, seed load and zero-seed fallback.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned        WIDTH    = 8,
  parameter int unsigned        OUT_BITS = 8,
  parameter logic [WIDTH-1:0]   TAPS     = WIDTH'(TAPS8),
  parameter logic [WIDTH-1:0]   INIT     = WIDTH'(1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_value,
  output logic [OUT_BITS-1:0] low_bits,
  output logic                zero_load_c
);

  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] next_value_c;
  logic             seed_zero_c;

  always_comb begin
    seed_zero_c  = (load_value == '0);
    zero_load_c  = load && seed_zero_c;
    next_value_c = WIDTH'(lfsr_step(STEP_BITS'(value), STEP_BITS'(TAPS)));
  end

  // A zero seed would freeze the register, so it is replaced by INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else if (load) begin
      value <= seed_zero_c ? INIT : load_value;
    end else if (step) begin
      value <= next_value_c;
    end
  end

  assign low_bits = value[OUT_BITS-1:0];

endmodule

// File: rtl/lfsr_prng_stream.sv
// Dual LFSR word stream with seed handshake, warm-up discard and valid/ready output.
module lfsr_prng_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned            UP_BITS   = 16,
  parameter int unsigned            DOWN_BITS = 8,
  parameter int unsigned            OUT_BITS  = 8,
  parameter logic [UP_BITS-1:0]     UP_TAPS   = UP_BITS'(TAPS16),
  parameter logic [DOWN_BITS-1:0]   DOWN_TAPS = DOWN_BITS'(TAPS8),
  parameter logic [UP_BITS-1:0]     UP_INIT   = UP_BITS'(16'h00FF),
  parameter logic [DOWN_BITS-1:0]   DOWN_INIT = DOWN_BITS'(8'h0F),
  parameter int unsigned            WARMUP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic [UP_BITS-1:0]    seed_up,
  input  logic [DOWN_BITS-1:0]  seed_down,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_BITS-1:0]   out_data,
  output logic                  lockup,
  output logic [COUNT_BITS-1:0] out_count
);

  localparam logic [CNT_BITS-1:0] WARM_INIT = CNT_BITS'(WARMUP);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  state_t                state;
  logic [CNT_BITS-1:0]   warm_cnt;
  logic                  accept_c;
  logic                  xfer_c;
  logic                  step_c;
  logic                  up_zero_c;
  logic                  down_zero_c;
  logic [OUT_BITS-1:0]   up_low;
  logic [OUT_BITS-1:0]   down_low;

  // Seed load wins over a simultaneous output step.
  always_comb begin
    accept_c = (state == RUN) && seed_valid;
    xfer_c   = (state == RUN) && out_ready;
    step_c   = ((state == WARM) && (warm_cnt != '0)) || (xfer_c && !accept_c);
  end

  lfsr_core #(
    .WIDTH    (UP_BITS),
    .OUT_BITS (OUT_BITS),
    .TAPS     (UP_TAPS),
    .INIT     (UP_INIT)
  ) u_up (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step_c),
    .load        (accept_c),
    .load_value  (seed_up),
    .low_bits    (up_low),
    .zero_load_c (up_zero_c)
  );

  lfsr_core #(
    .WIDTH    (DOWN_BITS),
    .OUT_BITS (OUT_BITS),
    .TAPS     (DOWN_TAPS),
    .INIT     (DOWN_INIT)
  ) u_down (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step_c),
    .load        (accept_c),
    .load_value  (seed_down),
    .low_bits    (down_low),
    .zero_load_c (down_zero_c)
  );

  // WARM/RUN control with registered handshake flags and delivery counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WARM;
      warm_cnt   <= WARM_INIT;
      out_valid  <= 1'b0;
      seed_ready <= 1'b0;
      lockup     <= 1'b0;
      out_count  <= '0;
    end else begin
      lockup <= up_zero_c || down_zero_c;
      unique case (state)
        WARM: begin
          if (warm_cnt != '0) begin
            warm_cnt <= warm_cnt - CNT_ONE;
          end
          // A zero count means WARMUP=0: spend a single idle cycle here.
          if (warm_cnt <= CNT_ONE) begin
            state      <= RUN;
            out_valid  <= 1'b1;
            seed_ready <= 1'b1;
          end
        end
        RUN: begin
          if (accept_c) begin
            state      <= WARM;
            warm_cnt   <= WARM_INIT;
            out_valid  <= 1'b0;
            seed_ready <= 1'b0;
            out_count  <= '0;
          end else if (xfer_c) begin
            out_count <= out_count + COUNT_BITS'(1);
          end
        end
        default: begin
          state      <= WARM;
          warm_cnt   <= WARM_INIT;
          out_valid  <= 1'b0;
          seed_ready <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = up_low ^ down_low;

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Scoreboard bench for lfsr_prng_stream: cycle-level reference model feeds queues, monitor compares.
module tb_lfsr_prng_stream;

  localparam int unsigned UP_BITS   = 16;
  localparam int unsigned DOWN_BITS = 8;
  localparam int unsigned OUT_BITS  = 8;
  localparam logic [15:0] UP_TAPS   = 16'hB400;
  localparam logic [7:0]  DOWN_TAPS = 8'hB8;
  localparam logic [15:0] UP_INIT   = 16'h00FF;
  localparam logic [7:0]  DOWN_INIT = 8'h0F;
  localparam int unsigned WARMUP    = 4;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic        seed_ready;
  logic [15:0] seed_up;
  logic [7:0]  seed_down;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        lockup;
  logic [31:0] out_count;

  lfsr_prng_stream #(
    .UP_BITS   (UP_BITS),
    .DOWN_BITS (DOWN_BITS),
    .OUT_BITS  (OUT_BITS),
    .UP_TAPS   (UP_TAPS),
    .DOWN_TAPS (DOWN_TAPS),
    .UP_INIT   (UP_INIT),
    .DOWN_INIT (DOWN_INIT),
    .WARMUP    (WARMUP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_up    (seed_up),
    .seed_down  (seed_down),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lockup     (lockup),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] count;
  } word_t;

  typedef struct {
    bit valid;
    bit lock;
    bit in_reset;
  } cyc_t;

  word_t word_q[$];
  cyc_t  cyc_q[$];
  int    errors = 0;
  int    checks = 0;

  logic [15:0] m_up;
  logic [7:0]  m_down;
  logic [31:0] m_count;
  int          m_wait;
  bit          m_lock_next;

  // Reference step: shift left as arithmetic, append the parity of the tapped bits.
  function automatic logic [15:0] up_next(input logic [15:0] v);
    int unsigned x;
    x = 32'(v) * 2 + 32'($countones(v & UP_TAPS) % 2);
    return 16'(x % 65536);
  endfunction

  function automatic logic [7:0] down_next(input logic [7:0] v);
    int unsigned x;
    x = 32'(v) * 2 + 32'($countones(v & DOWN_TAPS) % 2);
    return 8'(x % 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_restart();
    for (int i = 0; i < int'(WARMUP); i++) begin
      m_up   = up_next(m_up);
      m_down = down_next(m_down);
    end
    m_wait  = (WARMUP > 0) ? int'(WARMUP) : 1;
    m_count = 0;
  endtask

  // Drive one cycle of stimulus and advance the model by the same cycle.
  task automatic cycle(input bit rst, input bit rdy, input bit sv,
                       input logic [15:0] su, input logic [7:0] sd);
    cyc_t  c;
    word_t w;
    @(posedge clk);
    #2;
    rst_n      = !rst;
    out_ready  = rdy;
    seed_valid = sv;
    seed_up    = su;
    seed_down  = sd;
    if (rst) begin
      m_up        = UP_INIT;
      m_down      = DOWN_INIT;
      model_restart();
      m_lock_next = 1'b0;
      c = '{valid: 1'b0, lock: 1'b0, in_reset: 1'b1};
    end else begin
      c = '{valid: (m_wait == 0), lock: m_lock_next, in_reset: 1'b0};
      m_lock_next = 1'b0;
      if (c.valid) begin
        if (rdy) begin
          w.data  = m_up[7:0] ^ m_down;
          w.count = m_count;
          word_q.push_back(w);
        end
        if (sv) begin
          m_lock_next = (su == 16'h0) || (sd == 8'h0);
          m_up   = (su == 16'h0) ? UP_INIT : su;
          m_down = (sd == 8'h0) ? DOWN_INIT : sd;
          model_restart();
        end else if (rdy) begin
          m_up    = up_next(m_up);
          m_down  = down_next(m_down);
          m_count = m_count + 1;
        end
      end else begin
        m_wait--;
      end
    end
    cyc_q.push_back(c);
  endtask

  // Monitor: compares every cycle on the falling edge, independent of the driver.
  initial begin
    cyc_t       c;
    word_t      w;
    bit         prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (cyc_q.size() == 0) begin
        check("cycle_expectation_present", 32'(cyc_q.size()), 32'd1);
      end else begin
        c = cyc_q.pop_front();
        check("out_valid", 32'(out_valid), 32'(c.valid));
        check("seed_ready", 32'(seed_ready), 32'(c.valid));
        check("lockup", 32'(lockup), 32'(c.lock));
        if (c.in_reset) check("out_count_reset", out_count, 32'd0);
      end
      if (prev_hold && out_valid) check("stall_hold_data", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        if (word_q.size() == 0) begin
          check("word_expected", 32'd0, 32'd1);
        end else begin
          w = word_q.pop_front();
          check("out_data", 32'(out_data), 32'(w.data));
          check("out_count", out_count, w.count);
        end
      end
      prev_hold = out_valid && !out_ready && rst_n;
      prev_data = out_data;
    end
  end

  initial begin
    bit          rdy;
    bit          sv;
    logic [15:0] su;
    logic [7:0]  sd;
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    seed_valid = 1'b0;
    seed_up    = '0;
    seed_down  = '0;
    m_up        = UP_INIT;
    m_down      = DOWN_INIT;
    m_lock_next = 1'b0;
    model_restart();

    repeat (3) cycle(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (30) cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);

    // Seed together with a transfer, then free-running words.
    cycle(1'b0, 1'b1, 1'b1, 16'h0001, 8'h01);
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);

    // Same seed replayed under random backpressure.
    cycle(1'b0, 1'b0, 1'b1, 16'h0001, 8'h01);
    repeat (60) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0, 8'h0);

    // Zero seeds fall back to INIT and pulse lockup.
    cycle(1'b0, 1'b1, 1'b1, 16'h0000, 8'h01);
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'hACE1, 8'h00);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);

    // Reset in the middle of a post-seed warm-up.
    cycle(1'b0, 1'b1, 1'b1, 16'h1234, 8'h56);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
    repeat (15) cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);

    repeat (400) begin
      rdy = ($urandom_range(0, 3) != 0);
      sv  = ($urandom_range(0, 19) == 0);
      su  = 16'($urandom);
      sd  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) su = 16'h0;
      if ($urandom_range(0, 7) == 0) sd = 8'h0;
      cycle(1'b0, rdy, sv, su, sd);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

    @(negedge clk);
    #1;
    check("words_drained", 32'(word_q.size()), 32'd0);
    check("cycles_drained", 32'(cyc_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
